// File: rtl/rf_host_arb.sv
// rf_host_arb: shares the register-file / memory-manager ports between the
// CPU pipeline and a host/debug port. The CPU owns the ports by default. A
// host access stalls the CPU, drains one cycle, performs a single byte read or
// write through the normal memory-manager path, then hands the ports back. A
// gap counter then holds off further host grants so the CPU can make progress.
module rf_host_arb #(
    parameter int CPU_GAP = 4,
    parameter int GAP_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_wr_en,
    input  logic [7:0] cpu_wr_addr,
    input  logic [7:0] cpu_din,
    input  logic [7:0] cpu_rd_addr,
    output logic       cpu_stall,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       host_ack,
    output logic       mm_wr_en,
    output logic [7:0] mm_wr_addr,
    output logic [7:0] mm_din,
    output logic [7:0] mm_rd_addr,
    input  logic [7:0] mm_dout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        ACCESS  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(CPU_GAP);

    state_t           state, state_nxt;
    logic             lat_we;
    logic [7:0]       lat_addr;
    logic [7:0]       lat_wdata;
    logic [GAP_W-1:0] gap_cnt;
    logic             grant;
    logic             wr_en_raw;

    // A host request is only accepted from IDLE once the CPU gap has elapsed.
    assign grant = (state == IDLE) && host_req && (gap_cnt == '0);

    // State, latched host request, gap counter and captured read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_addr   <= 8'h00;
            lat_wdata  <= 8'h00;
            gap_cnt    <= '0;
            host_rdata <= 8'h00;
        end else begin
            state <= state_nxt;
            // Host fields are sampled only at grant; the host may change them later.
            if (grant) begin
                lat_we    <= host_we;
                lat_addr  <= host_addr;
                lat_wdata <= host_wdata;
            end
            if (state == DONE)
                gap_cnt <= GAP_INIT;
            else if (state == IDLE && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            // mm_dout now reflects the latched address presented in ACCESS.
            if (state == CAPTURE)
                host_rdata <= mm_dout;
        end
    end

    // Next-state and port steering; the CPU path is the default everywhere.
    always_comb begin
        state_nxt  = state;
        cpu_stall  = 1'b1;
        host_ack   = 1'b0;
        wr_en_raw  = 1'b0;
        mm_wr_addr = cpu_wr_addr;
        mm_din     = cpu_din;
        mm_rd_addr = cpu_rd_addr;
        case (state)
            IDLE: begin
                cpu_stall = 1'b0;
                wr_en_raw = cpu_wr_en;  // CPU write in the grant cycle still lands
                if (grant)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Quiet cycle so the memory manager's write bypass settles.
                state_nxt = ACCESS;
            end
            ACCESS: begin
                mm_rd_addr = lat_addr;
                if (lat_we) begin
                    wr_en_raw  = 1'b1;
                    mm_wr_addr = lat_addr;
                    mm_din     = lat_wdata;
                    state_nxt  = DONE;
                end else begin
                    state_nxt  = CAPTURE;
                end
            end
            CAPTURE: begin
                mm_rd_addr = lat_addr;
                state_nxt  = DONE;
            end
            DONE: begin
                host_ack  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A reset cycle never writes, even if it coincides with a host ACCESS.
    assign mm_wr_en = wr_en_raw & ~rst;

endmodule

// File: doc/rf_host_arb.md
Name: rf_host_arb

Overview:
- Arbitrates the 128x8 register-file / memory-manager access ports between the CPU pipeline and a host/debug port.
- The CPU owns the ports by default.
- A host request stalls the CPU, drains one cycle, performs a single byte read or write through the normal memory-manager path (special registers included), then returns the ports to the CPU.
- A programmable gap guarantees the CPU forward progress between host accesses.

Parameters:
- CPU_GAP, 4: minimum number of IDLE cycles after a host access completes before the next host grant (0 = back-to-back).
- GAP_W, 3: width of the gap counter; must hold CPU_GAP.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_wr_en  in  1  CPU write enable
- cpu_wr_addr  in  8  CPU write address
- cpu_din  in  8  CPU write data
- cpu_rd_addr  in  8  CPU read address
- cpu_stall  out  1  freeze CPU pipeline
- host_req  in  1  host access request (level)
- host_we  in  1  1 = write, 0 = read
- host_addr  in  8  host byte address
- host_wdata  in  8  host write data
- host_rdata  out  8  host read data, valid with host_ack
- host_ack  out  1  one-cycle completion pulse
- mm_wr_en  out  1  to memory manager wr_en
- mm_wr_addr  out  8  to memory manager wr_addr
- mm_din  out  8  to memory manager din
- mm_rd_addr  out  8  to memory manager rd_addr
- mm_dout  in  8  memory manager dout; reflects the rd_addr presented one cycle earlier

Behaviour:
- Reset (sync, active-high):
  - state = IDLE; host_ack = 0; host_rdata = 0; gap_cnt = 0; latched host request registers = 0.
  - cpu_stall = 0.
  - mm_wr_en is forced 0 in any cycle with rst = 1.
- States: IDLE, DRAIN, ACCESS, CAPTURE, DONE. State is registered; all outputs are decoded from state and registers.
- IDLE:
  - mm_* outputs pass through the cpu_* inputs; cpu_stall = 0.
  - If gap_cnt != 0, decrement.
  - If host_req = 1 and gap_cnt = 0: latch host_we, host_addr, host_wdata; go to DRAIN.
  - The CPU write in the grant cycle completes normally.
- DRAIN:
  - cpu_stall = 1; mm_wr_en = 0; mm_rd_addr = cpu_rd_addr.
  - Go to ACCESS.
  - Purpose: lets the memory manager's write-bypass registers settle.
- ACCESS:
  - cpu_stall = 1; mm_rd_addr = latched addr.
  - Write request: mm_wr_en = 1, mm_wr_addr = latched addr, mm_din = latched wdata; go to DONE.
  - Read request: mm_wr_en = 0; go to CAPTURE.
- CAPTURE:
  - cpu_stall = 1; mm_wr_en = 0; mm_rd_addr held at latched addr.
  - host_rdata <= mm_dout; go to DONE.
- DONE:
  - cpu_stall = 1; mm_wr_en = 0.
  - host_ack = 1 for exactly this cycle; gap_cnt <= CPU_GAP; go to IDLE.
- Latency, counted from the IDLE grant cycle (cycle 0):
  - Write: ack in cycle 3; RAM/special register updated at the end of cycle 2.
  - Read: ack in cycle 4; host_rdata valid from cycle 4 and held until the next read capture.
- Handshake:
  - Host fields are sampled only at grant; they may change afterwards.
  - The host must drop host_req in the cycle after ack.
  - If host_req is still high in the IDLE cycle after DONE, it is a new request, granted only once gap_cnt = 0.
  - With CPU_GAP = 0 it is regranted immediately.
- cpu_stall is high in DRAIN, ACCESS, CAPTURE and DONE:
  - Write access: 3 stall cycles.
  - Read access: 4 stall cycles.
- Address handling:
  - Host addresses are passed unmodified.
  - Accesses to FSR (4), STATUS (3), IN0 (5), IN1 (1), OUT0 (6) and OUT1 (7) hit the special registers exactly as CPU accesses do; this is the intended debug path.
- Reset mid-transaction: the access is aborted, no ack is produced, and a write is not performed if rst coincides with ACCESS.
- host_req arriving while not in IDLE is ignored until the FSM returns to IDLE.

Test Plan:
- Host write: CPU idle, host_req with we=1, addr=0x20, wdata=0xA5 -> cpu_stall for 3 cycles, mm_wr_en pulses in cycle 2 with addr 0x20 / data 0xA5, host_ack in cycle 3; a subsequent CPU read of 0x20 returns 0xA5.
- Host read: RAM[0x31]=0x5C, host read addr 0x31 -> host_ack in cycle 4, host_rdata=0x5C, cpu_stall for 4 cycles, mm_wr_en never asserted.
- Collision: CPU writes 0x77 to 0x40 in the grant cycle while the host reads 0x40 -> CPU write lands, host_rdata=0x77, and the CPU sees no lost write.
- Gap: CPU_GAP=4, host_req held high continuously -> successive grants separated by exactly 4 IDLE cycles with cpu_stall=0; with CPU_GAP=0 they are back-to-back.
- Special register: host writes 0x60 to addr 0x04 -> the memory manager's FSR becomes 0x60 (bank=3); host read of addr 0x03 returns the current STATUS.
- Reset in ACCESS of a host write to 0x22 -> no write to 0x22, no host_ack, state IDLE, cpu_stall=0 in the next cycle.
